// File: rtl/memshare_alloc_sched_if.sv
// memshare_alloc_sched_if: request, RFMU and grant signals of the memShare sequencer.
// Suffixes are from the scheduler's view; slave = scheduler, master = requester/RFMU side.
interface memshare_alloc_sched_if #(
    parameter int REQ_NUM = 4
);
    logic               rqst_valid_i;
    logic               rqst_ready_o;
    logic [REQ_NUM-1:0] rqst_pattern_i;
    logic               rfmu_shift_req_o;
    logic               rfmu_ack_i;
    logic               rfmu_isGtr_i;
    logic               pipeCycle_begin_o;
    logic               isGtr_o;
    logic               alloc_valid_o;
    logic [REQ_NUM-1:0] alloc_grant_o;
    logic               set_done_o;
    logic               rqst_err_o;

    modport slave (
        input  rqst_valid_i, rqst_pattern_i, rfmu_ack_i, rfmu_isGtr_i,
        output rqst_ready_o, rfmu_shift_req_o, pipeCycle_begin_o, isGtr_o,
        output alloc_valid_o, alloc_grant_o, set_done_o, rqst_err_o
    );

    modport master (
        output rqst_valid_i, rqst_pattern_i, rfmu_ack_i, rfmu_isGtr_i,
        input  rqst_ready_o, rfmu_shift_req_o, pipeCycle_begin_o, isGtr_o,
        input  alloc_valid_o, alloc_grant_o, set_done_o, rqst_err_o
    );
endinterface

// File: rtl/memshare_alloc_sched.sv
// memshare_alloc_sched: serialises a request pattern set into round-robin grants,
// one RFMU shift-generation handshake per grant.
// Ports: sys_clk, rst (async, active-high), bus (memshare_alloc_sched_if.slave):
//   rqst_valid_i/rqst_ready_o/rqst_pattern_i  - pattern set handshake
//   rfmu_shift_req_o/rfmu_ack_i/rfmu_isGtr_i   - RFMU shift generation
//   pipeCycle_begin_o, isGtr_o                 - skid buffer control
//   alloc_valid_o/alloc_grant_o, set_done_o, rqst_err_o
// Optional macro MEMSHARE_SCHED_TIMEOUT_EN adds an RFMU ack watchdog.
module memshare_alloc_sched #(
    parameter int MAX_ALLOC_SEQ_NUM = 2,
    parameter int REQ_NUM           = 4,
    parameter int TIMEOUT_CYC       = 16
) (
    input logic                   sys_clk,
    input logic                   rst,
    memshare_alloc_sched_if.slave bus
);
    localparam int PTR_W = $clog2(REQ_NUM);
    localparam int CNT_W = $clog2(REQ_NUM + 1);
    localparam int SEQ_W = $clog2(MAX_ALLOC_SEQ_NUM + 1);

    if (REQ_NUM < 2 || MAX_ALLOC_SEQ_NUM < 1 || TIMEOUT_CYC < 1) begin : g_cfg_chk
        $error("memshare_alloc_sched: illegal parameters");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_GEN,
        ALLOC,
        DONE
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   rr_q;
    logic [REQ_NUM-1:0] mask_q;
    logic [SEQ_W-1:0]   seq_q;
    logic               ready_q;
    logic               shreq_q;
    logic               pcb_q;
    logic               gtr_q;
    logic               av_q;
    logic [REQ_NUM-1:0] grant_q;
    logic [PTR_W-1:0]   gidx_q;
    logic               done_q;
    logic               err_q;
`ifdef MEMSHARE_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]    wdog_q;
    logic [WD_W-1:0]    wdog_d;
    assign wdog_d = wdog_q + WD_W'(1);
`endif

    logic [CNT_W-1:0]   pcnt;
    logic               bad_set;
    logic [REQ_NUM-1:0] grant_d;
    logic [PTR_W-1:0]   gidx_d;
    logic [PTR_W-1:0]   idx;
    logic               found;
    logic [REQ_NUM-1:0] left_mask;

    always_comb begin
        pcnt = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            pcnt = pcnt + CNT_W'(bus.rqst_pattern_i[i]);
        end
    end

    assign bad_set = (pcnt == '0) || (int'(pcnt) > MAX_ALLOC_SEQ_NUM);

    // Cyclic first-one search starting at rr_q; PTR_W-bit add wraps.
    always_comb begin
        grant_d = '0;
        gidx_d  = '0;
        idx     = '0;
        found   = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            idx = rr_q + PTR_W'(i);
            if (!found && mask_q[idx]) begin
                found        = 1'b1;
                gidx_d       = idx;
                grant_d[idx] = 1'b1;
            end
        end
    end

    assign left_mask = mask_q & ~grant_q;

    // Outputs are registered: each is set on the transition into the
    // state that owns it, so it lines up with state_q.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            mask_q  <= '0;
            seq_q   <= '0;
            ready_q <= 1'b1;
            shreq_q <= 1'b0;
            pcb_q   <= 1'b0;
            gtr_q   <= 1'b0;
            av_q    <= 1'b0;
            grant_q <= '0;
            gidx_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MEMSHARE_SCHED_TIMEOUT_EN
            wdog_q  <= '0;
`endif
        end else begin
            pcb_q   <= 1'b0;
            av_q    <= 1'b0;
            grant_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.rqst_valid_i && ready_q) begin
                        if (bad_set) begin
                            err_q <= 1'b1;
                        end else begin
                            mask_q  <= bus.rqst_pattern_i;
                            seq_q   <= '0;
                            state_q <= SHIFT_GEN;
                            ready_q <= 1'b0;
                            shreq_q <= 1'b1;
                            pcb_q   <= 1'b1;
`ifdef MEMSHARE_SCHED_TIMEOUT_EN
                            wdog_q  <= '0;
`endif
                        end
                    end
                end
                SHIFT_GEN: begin
                    if (bus.rfmu_ack_i) begin
                        gtr_q   <= bus.rfmu_isGtr_i;
                        state_q <= ALLOC;
                        shreq_q <= 1'b0;
                        av_q    <= 1'b1;
                        grant_q <= grant_d;
                        gidx_q  <= gidx_d;
                    end
`ifdef MEMSHARE_SCHED_TIMEOUT_EN
                    // Abort after TIMEOUT_CYC ack-less cycles; rr_q untouched.
                    else if (wdog_d == WD_W'(TIMEOUT_CYC)) begin
                        state_q <= IDLE;
                        shreq_q <= 1'b0;
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        mask_q  <= '0;
                        wdog_q  <= '0;
                    end else begin
                        wdog_q  <= wdog_d;
                    end
`endif
                end
                ALLOC: begin
                    mask_q <= left_mask;
                    rr_q   <= gidx_q + PTR_W'(1);
                    seq_q  <= seq_q + SEQ_W'(1);
                    if (left_mask != '0) begin
                        state_q <= SHIFT_GEN;
                        shreq_q <= 1'b1;
`ifdef MEMSHARE_SCHED_TIMEOUT_EN
                        wdog_q  <= '0;
`endif
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rqst_ready_o      = ready_q;
    assign bus.rfmu_shift_req_o  = shreq_q;
    assign bus.pipeCycle_begin_o = pcb_q;
    assign bus.isGtr_o           = gtr_q;
    assign bus.alloc_valid_o     = av_q;
    assign bus.alloc_grant_o     = grant_q;
    assign bus.set_done_o        = done_q;
    assign bus.rqst_err_o        = err_q;
endmodule

// File: tb/tb_memshare_alloc_sched.sv
// tb_memshare_alloc_sched: directed and randomized sets checked against a
// queue-based round-robin model; define MEMSHARE_SCHED_TIMEOUT_EN for watchdog cases.
module tb_memshare_alloc_sched;
    localparam int N  = 4;
    localparam int M  = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memshare_alloc_sched_if #(.REQ_NUM(N)) bus ();

    memshare_alloc_sched #(
        .MAX_ALLOC_SEQ_NUM(M),
        .REQ_NUM(N),
        .TIMEOUT_CYC(TO)
    ) dut (
        .sys_clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   errs   = 0;
    int   checks = 0;
    int   rr_m   = 0;
    logic gtr_m  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic quiet();
        bus.rqst_valid_i   = 1'b0;
        bus.rqst_pattern_i = '0;
        bus.rfmu_ack_i     = 1'b0;
        bus.rfmu_isGtr_i   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.rqst_ready_o), 1);
        chk({tag, "_shreq"}, 32'(bus.rfmu_shift_req_o), 0);
        chk({tag, "_pcb"},   32'(bus.pipeCycle_begin_o), 0);
        chk({tag, "_gtr"},   32'(bus.isGtr_o), 0);
        chk({tag, "_av"},    32'(bus.alloc_valid_o), 0);
        chk({tag, "_grant"}, 32'(bus.alloc_grant_o), 0);
        chk({tag, "_done"},  32'(bus.set_done_o), 0);
        chk({tag, "_err"},   32'(bus.rqst_err_o), 0);
    endtask

    // Starts and ends at a negedge. dly/gmode < 0 mean random;
    // gmode bit k is the isGtr for sequence k. abort_seq >= 0 resets there.
    task automatic run_set(input logic [N-1:0] pat, input int dly,
                           input int gmode, input int abort_seq);
        int             q[$];
        logic [N-1:0]   m;
        int             p;
        int             d;
        logic           g;
        int             pc;
        pc = $countones(pat);
        chk("acc_ready", 32'(bus.rqst_ready_o), 1);
        bus.rqst_valid_i   = 1'b1;
        bus.rqst_pattern_i = pat;
        @(negedge clk);
        bus.rqst_valid_i   = 1'b0;
        bus.rqst_pattern_i = N'($urandom);
        if (pc == 0 || pc > M) begin
            chk("rej_err", 32'(bus.rqst_err_o), 1);
            chk("rej_shreq", 32'(bus.rfmu_shift_req_o), 0);
            chk("rej_ready", 32'(bus.rqst_ready_o), 1);
            @(negedge clk);
            chk("rej_err_once", 32'(bus.rqst_err_o), 0);
            chk("rej_shreq2", 32'(bus.rfmu_shift_req_o), 0);
            return;
        end
        m = pat;
        p = rr_m;
        while (m != '0) begin
            for (int i = 0; i < N; i++) begin
                if (m[(p + i) % N]) begin
                    q.push_back((p + i) % N);
                    p = ((p + i) % N + 1) % N;
                    m[q[$]] = 1'b0;
                    break;
                end
            end
        end
        foreach (q[k]) begin
            d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            g = (gmode < 0) ? 1'($urandom_range(0, 1)) : 1'((gmode >> k) & 1);
            if (k == abort_seq) begin
                rst = 1'b1;
                #1;
                chk_all_zero("arst");
                quiet();
                @(negedge clk);
                rst   = 1'b0;
                rr_m  = 0;
                gtr_m = 1'b0;
                return;
            end
            for (int j = 0; j <= d; j++) begin
                chk("sg_shreq", 32'(bus.rfmu_shift_req_o), 1);
                chk("sg_pcb", 32'(bus.pipeCycle_begin_o), 32'(k == 0 && j == 0));
                chk("sg_ready", 32'(bus.rqst_ready_o), 0);
                chk("sg_av", 32'(bus.alloc_valid_o), 0);
                bus.rfmu_ack_i   = (j == d);
                bus.rfmu_isGtr_i = (j == d) ? g : ~g;
                @(negedge clk);
            end
            gtr_m = g;
            rr_m  = (q[k] + 1) % N;
            chk("al_av", 32'(bus.alloc_valid_o), 1);
            chk("al_grant", 32'(bus.alloc_grant_o), 32'(1) << q[k]);
            chk("al_gtr", 32'(bus.isGtr_o), 32'(gtr_m));
            chk("al_shreq", 32'(bus.rfmu_shift_req_o), 0);
            chk("al_err", 32'(bus.rqst_err_o), 0);
            bus.rfmu_ack_i   = 1'b1;
            bus.rfmu_isGtr_i = ~g;
            @(negedge clk);
            bus.rfmu_ack_i   = 1'b0;
        end
        chk("dn_done", 32'(bus.set_done_o), 1);
        chk("dn_gtr", 32'(bus.isGtr_o), 32'(gtr_m));
        chk("dn_shreq", 32'(bus.rfmu_shift_req_o), 0);
        chk("dn_ready", 32'(bus.rqst_ready_o), 0);
        @(negedge clk);
        chk("id_ready", 32'(bus.rqst_ready_o), 1);
        chk("id_done", 32'(bus.set_done_o), 0);
        chk("id_gtr", 32'(bus.isGtr_o), 32'(gtr_m));
    endtask

    initial begin
        quiet();
        @(negedge clk);
        chk_all_zero("rst");
        rst = 1'b0;
        @(negedge clk);

        run_set(4'b0010, 0, 1, -1);
        run_set(4'b0011, 0, 1, -1);
        run_set(4'b0111, -1, -1, -1);
        run_set(4'b0000, -1, -1, -1);
        run_set(4'b0100, -1, -1, -1);
        run_set(4'b1001, 3, -1, -1);
        run_set(4'b0110, 0, -1, 1);
        chk_all_zero("post_rst");
        run_set(4'b0101, 0, 2, -1);

`ifdef MEMSHARE_SCHED_TIMEOUT_EN
        chk("to_ready", 32'(bus.rqst_ready_o), 1);
        bus.rqst_valid_i   = 1'b1;
        bus.rqst_pattern_i = 4'b0001;
        @(negedge clk);
        bus.rqst_valid_i   = 1'b0;
        for (int j = 0; j < TO; j++) begin
            chk("to_shreq", 32'(bus.rfmu_shift_req_o), 1);
            chk("to_err_early", 32'(bus.rqst_err_o), 0);
            @(negedge clk);
        end
        chk("to_err", 32'(bus.rqst_err_o), 1);
        chk("to_shreq_drop", 32'(bus.rfmu_shift_req_o), 0);
        chk("to_ready_back", 32'(bus.rqst_ready_o), 1);
        chk("to_no_done", 32'(bus.set_done_o), 0);
        @(negedge clk);
        chk("to_err_once", 32'(bus.rqst_err_o), 0);
`endif
        run_set(4'b0001, TO - 1, 1, -1);

        for (int i = 0; i < 40; i++) begin
            run_set(N'($urandom_range(0, 15)), -1, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
